alu_arith_serial: RTL
=====================

// Module: alu_arith_serial
// PURPOSE
//  Parametrised, multi-cycle arithmetic unit for the Gumnut datapath. Performs ADD/ADDC/SUB/SUBC
//  on WIDTH-bit operands through a SLICE-bit adder iterated over WIDTH/SLICE cycles. Operands
//  enter and results leave over valid/ready handshakes. Drives Z, C and V flags for the flag
//  register, so wider data paths do not need a wide combinational carry chain.
// PARAMETERS
//  WIDTH  8  operand/result width in bits
//  SLICE  4  adder slice width; WIDTH % SLICE must be 0, otherwise elaboration fails ($error)
// PORTS
//  clk_i        in   1      clock, rising edge
//  rst_i        in   1      reset, synchronous, active-high
//  in_valid_i   in   1      operation request valid
//  in_ready_o   out  1      unit can accept a request this cycle
//  rs_i         in   WIDTH  operand A
//  op2_i        in   WIDTH  operand B
//  ALUOp_i      in   2      00 ADD, 01 ADDC, 10 SUB, 11 SUBC (bit1 = subtract)
//  carry_i      in   1      carry flag in (used by ADDC/SUBC only)
//  out_valid_o  out  1      result valid
//  out_ready_i  in   1      consumer accepts result
//  res_o        out  WIDTH  result
//  carry_o      out  1      ADD: carry-out; SUB: borrow (raw carry-out XOR ALUOp[1])
//  zero_o       out  1      res_o == 0
//  ovf_o        out  1      signed overflow = carry into MSB XOR carry out of MSB (raw adder)
// BEHAVIOUR
//  - N = WIDTH/SLICE. FSM states are IDLE, RUN, DONE.
//  - Reset: state IDLE, slice counter 0, all outputs 0 except in_ready_o = 1. A reset during
//    RUN or DONE drops the in-flight operation; no result is emitted.
//  - Ready signal: in_ready_o = (state==IDLE) | (state==DONE & out_ready_i). This is a
//    combinational path from out_ready_i.
//  - Accept: on an edge where in_valid_i & in_ready_o, the unit latches the operands.
//    * A = rs_i.
//    * B = op2_i, or ~op2_i when ALUOp_i[1] is set.
//    * cin: ADD=0, ADDC=carry_i, SUB=1, SUBC=~carry_i.
//    * The subtract bit is also latched.
//    The next state is RUN, with the slice counter cleared.
//  - RUN: each edge adds slice k of A, slice k of B and the running carry. It writes res[k*SLICE +: SLICE]
//    and stores the slice carry-out as the next carry-in. After slice N-1 (counter == N-1)
//    the state becomes DONE. Flags are computed from the final slice.
//  - Latency: out_valid_o rises exactly N edges after the accepting edge.
//  - DONE: out_valid_o = 1. res_o and the flags stay stable until out_ready_i. On the
//    handshake edge the next state is IDLE, or RUN if a new request is accepted on the same edge.
//  - Inputs are ignored outside the accepting edge. Changes on rs_i/op2_i/ALUOp_i during
//    RUN have no effect.
//  - out_valid_o is 0 in IDLE and RUN. res_o/flags hold their last values outside DONE
//    (don't-care to consumers).
//  - All arithmetic is modulo 2^WIDTH. No sign extension.
//  - SLICE == WIDTH degenerates to single-cycle operation (N = 1).
// STRUCTURE
//  - Package gumnut_alu_pkg holds the ALUOp encodings (ALU_ADD, ALU_ADDC, ALU_SUB, ALU_SUBC)
//    and the FSM state enum. This unit and the decoder share them.
//  - Sub-module adder_slice #(W) has ports a, b, cin, sum, cout and c_msb_in, the carry into the MSB used for V.
//    It is instantiated once with W = SLICE.
//  - The top level holds the FSM, the operand/result registers and the slice counter
//    ($clog2(N) bits, minimum 1).
// TESTING  (WIDTH=8, SLICE=4 unless stated)
//  1. ADD 0x7F+0x01 -> res 0x80, C=0, V=1, Z=0. out_valid_o rises 2 edges after accept.
//  2. SUB 0x10-0x20 -> res 0xF0, C=1 (borrow), V=0, Z=0.
//     SUB 0x20-0x10 -> res 0x10, C=0.
//  3. SUBC 0x00-0x00 with carry_i=1 -> res 0xFF, C=1.
//     ADDC 0xFF+0x00 with carry_i=1 -> res 0x00, C=1, Z=1.
//  4. Hold out_ready_i=0 for 5 cycles in DONE: res/flags stay stable and in_ready_o=0.
//     Then assert out_ready_i together with in_valid_i (ADD 1+1): both handshakes complete
//     and res 0x02 is valid 2 edges later.
//  5. Assert rst_i for one cycle mid-RUN: next cycle out_valid_o=0, in_ready_o=1, and no
//     result appears. A following ADD 3+4 returns 0x07 normally.
//  6. Sweep WIDTH=16 with SLICE in {1,4,16}, 1000 random ops, randomised in_valid/out_ready,
//     checked against a behavioural model. Latency must equal WIDTH/SLICE every time.
//     WIDTH=8, SLICE=3 must fail elaboration.

Source files
------------

// File: rtl/gumnut_alu_pkg.sv
// Shared ALU definitions for the Gumnut datapath.
// Holds the ALUOp encodings and the serial ALU state type.
package gumnut_alu_pkg;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_ADDC = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;
    localparam logic [1:0] ALU_SUBC = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } alu_state_t;

    // Initial carry into slice 0 for each operation.
    function automatic logic op_cin(input logic [1:0] op, input logic c);
        logic r;
        r = 1'b0;
        unique case (op)
            ALU_ADD:  r = 1'b0;
            ALU_ADDC: r = c;
            ALU_SUB:  r = 1'b1;
            ALU_SUBC: r = ~c;
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// W-bit ripple adder slice with carry-out and carry into the MSB.
// The MSB carry-in lets the top level derive signed overflow.
module adder_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         c_msb_in
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

    generate
        if (W == 1) begin : g_one
            assign c_msb_in = cin;
        end else begin : g_multi
            logic [W-1:0] low;
            assign low = {1'b0, a[W-2:0]}
                       + {1'b0, b[W-2:0]}
                       + {{(W-1){1'b0}}, cin};
            assign c_msb_in = low[W-1];
        end
    endgenerate

endmodule

// File: rtl/alu_arith_serial.sv
// Multi-cycle ADD/ADDC/SUB/SUBC unit iterating a SLICE-bit adder.
// Operands and results move over valid/ready handshakes.
module alu_arith_serial
    import gumnut_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] rs_i,
    input  logic [WIDTH-1:0] op2_i,
    input  logic [1:0]       ALUOp_i,
    input  logic             carry_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] res_o,
    output logic             carry_o,
    output logic             zero_o,
    output logic             ovf_o
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (WIDTH % SLICE != 0) begin : g_bad_slice
            $error("alu_arith_serial: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    alu_state_t state;
    alu_state_t state_nx;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] work_q;
    logic             carry_q;
    logic             sub_q;

    logic [WIDTH-1:0] res_q;
    logic             c_q;
    logic             z_q;
    logic             v_q;

    logic             accept;
    logic             last;

    logic [SLICE-1:0] sum;
    logic             cout;
    logic             c_msb;
    logic [WIDTH-1:0] res_nx;

    adder_slice #(
        .W(SLICE)
    ) u_slice (
        .a        (a_q[SLICE-1:0]),
        .b        (b_q[SLICE-1:0]),
        .cin      (carry_q),
        .sum      (sum),
        .cout     (cout),
        .c_msb_in (c_msb)
    );

    // Slices enter at the top and shift down; after N steps work is the result.
    assign res_nx = (work_q >> SLICE) | (WIDTH'(sum) << (WIDTH - SLICE));
    assign last   = (cnt == LAST);
    assign accept = in_valid_i & in_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        unique case (state)
            ST_IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (last) state_nx = ST_DONE;
            end
            ST_DONE: begin
                out_valid_o = 1'b1;
                in_ready_o  = out_ready_i;
                if (out_ready_i) begin
                    state_nx = in_valid_i ? ST_RUN : ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            res_q   <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            v_q     <= 1'b0;
        end else if (accept) begin
            cnt     <= '0;
            a_q     <= rs_i;
            b_q     <= ALUOp_i[1] ? ~op2_i : op2_i;
            carry_q <= op_cin(ALUOp_i, carry_i);
            sub_q   <= ALUOp_i[1];
            work_q  <= '0;
        end else if (state == ST_RUN) begin
            cnt     <= cnt + CW'(1);
            a_q     <= a_q >> SLICE;
            b_q     <= b_q >> SLICE;
            carry_q <= cout;
            work_q  <= res_nx;
            if (last) begin
                // Publish only on the final slice so outputs stay put elsewhere.
                res_q <= res_nx;
                c_q   <= cout ^ sub_q;
                z_q   <= (res_nx == '0);
                v_q   <= c_msb ^ cout;
            end
        end
    end

    assign res_o   = res_q;
    assign carry_o = c_q;
    assign zero_o  = z_q;
    assign ovf_o   = v_q;

endmodule
